// File: rtl/sha_miner_pkg.sv
// Shared definitions for the nonce sweeper: header geometry, sweep FSM states and job status codes.
package sha_miner_pkg;
    localparam int HDR_W    = 640;
    localparam int PREFIX_W = 608;
    localparam int HASH_W   = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] STATUS_FOUND     = 2'd0;
    localparam logic [1:0] STATUS_EXHAUSTED = 2'd1;
    localparam logic [1:0] STATUS_BAD_BITS  = 2'd2;
    localparam logic [1:0] STATUS_ABORTED   = 2'd3;

    // Header integers are little-endian on the wire, so nBits and the nonce get byte-reversed.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/nbits_to_target.sv
// Expands compact nBits difficulty into a 256-bit target and flags encodings that cannot be a valid target.
module nbits_to_target
    import sha_miner_pkg::*;
(
    input  logic [31:0]       nbits,
    output logic [HASH_W-1:0] target,
    output logic              invalid
);
    logic [7:0]  exponent_s;
    logic [23:0] mantissa_s;
    logic [10:0] shift_s;

    assign exponent_s = nbits[31:24];
    assign mantissa_s = nbits[23:0];

    // Place the mantissa at byte position exponent-3, shifting right for tiny exponents.
    always_comb begin
        shift_s = 11'd0;
        target  = '0;
        if (exponent_s >= 8'd3) begin
            shift_s = {exponent_s, 3'b000} - 11'd24;
            target  = HASH_W'(mantissa_s) << shift_s;
        end else begin
            shift_s = 11'd24 - {exponent_s, 3'b000};
            target  = HASH_W'(mantissa_s) >> shift_s;
        end
    end

    assign invalid = nbits[23] | (exponent_s > 8'd32) | (mantissa_s == 24'd0);
endmodule

// File: rtl/nonce_sweeper.sv
// Sweeps a nonce range over one block-header prefix, one hasher request at a time,
// and reports the first nonce whose hash does not exceed the nBits target.
module nonce_sweeper #(
    parameter int HDR_W    = sha_miner_pkg::HDR_W,
    parameter int PREFIX_W = sha_miner_pkg::PREFIX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [PREFIX_W-1:0] job_prefix,
    input  logic [31:0]         nonce_start,
    input  logic [31:0]         nonce_end,
    input  logic                abort,
    output logic [HDR_W-1:0]    hdr_out,
    output logic                hdr_valid,
    input  logic                hdr_ready,
    input  logic [255:0]        hash_in,
    input  logic                hash_valid,
    output logic                found_valid,
    output logic [31:0]         found_nonce,
    output logic                done,
    output logic [1:0]          status,
    output logic [31:0]         hash_count
);
    import sha_miner_pkg::*;

    state_t              state_r;
    logic [PREFIX_W-1:0] prefix_r;
    logic [31:0]         nonce_r;
    logic [31:0]         end_r;
    logic [HASH_W-1:0]   target_r;
    logic [HASH_W-1:0]   hash_r;
    logic [HASH_W-1:0]   job_target_s;
    logic                job_invalid_s;
    logic                hit_s;
    logic                last_s;

    nbits_to_target u_target (
        .nbits   (bswap32(job_prefix[31:0])),
        .target  (job_target_s),
        .invalid (job_invalid_s)
    );

    assign hit_s  = (hash_r <= target_r);
    assign last_s = (nonce_r == end_r);

    // Sweep FSM; every output is registered and pulses (found_valid, done) clear by default.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            prefix_r    <= '0;
            nonce_r     <= 32'd0;
            end_r       <= 32'd0;
            target_r    <= '0;
            hash_r      <= '0;
            job_ready   <= 1'b1;
            hdr_out     <= '0;
            hdr_valid   <= 1'b0;
            found_valid <= 1'b0;
            found_nonce <= 32'd0;
            done        <= 1'b0;
            status      <= STATUS_FOUND;
            hash_count  <= 32'd0;
        end else begin
            found_valid <= 1'b0;
            done        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (job_valid && job_ready) begin
                        prefix_r   <= job_prefix;
                        nonce_r    <= nonce_start;
                        end_r      <= nonce_end;
                        target_r   <= job_target_s;
                        hash_count <= 32'd0;
                        job_ready  <= 1'b0;
                        if (job_invalid_s) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                            status  <= STATUS_BAD_BITS;
                        end else begin
                            state_r   <= ST_ISSUE;
                            hdr_out   <= {job_prefix, bswap32(nonce_start)};
                            hdr_valid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state_r   <= ST_DONE;
                        hdr_valid <= 1'b0;
                        done      <= 1'b1;
                        status    <= STATUS_ABORTED;
                    end else if (hdr_ready) begin
                        state_r   <= ST_WAIT;
                        hdr_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        status  <= STATUS_ABORTED;
                    end else if (hash_valid) begin
                        hash_r  <= hash_in;
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hash_count != 32'hFFFF_FFFF) begin
                        hash_count <= hash_count + 32'd1;
                    end
                    // A hit is still reported even when abort wins the status.
                    if (hit_s) begin
                        found_valid <= 1'b1;
                        found_nonce <= nonce_r;
                    end
                    if (abort) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        status  <= STATUS_ABORTED;
                    end else if (hit_s) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        status  <= STATUS_FOUND;
                    end else if (last_s) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        status  <= STATUS_EXHAUSTED;
                    end else begin
                        nonce_r   <= nonce_r + 32'd1;
                        hdr_out   <= {prefix_r, bswap32(nonce_r + 32'd1)};
                        hdr_valid <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    job_ready <= 1'b1;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    job_ready <= 1'b1;
                    hdr_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
